// File: rtl/rates_token_shaper.sv
// Message-granular token-bucket rate shaper for a valid/ready byte stream.
// A message is admitted only while byte credit is positive. Once admitted it
// runs to its last beat without further gating, and each beat is charged.
module rates_token_shaper #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 4,
  parameter int unsigned TOKEN_WIDTH         = 20,
  parameter int unsigned PERIOD_WIDTH        = 16,
  localparam int unsigned EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_enable,
  input  logic [PERIOD_WIDTH-1:0]          cfg_period,
  input  logic [TOKEN_WIDTH-1:0]           cfg_increment,
  input  logic [TOKEN_WIDTH-1:0]           cfg_burst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] in_data,
  input  logic                             in_last,
  input  logic [EMPTY_W-1:0]               in_empty,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] out_data,
  output logic                             out_last,
  output logic [EMPTY_W-1:0]               out_empty,
  output logic [TOKEN_WIDTH:0]             sts_tokens,
  output logic [31:0]                      sts_msg_count,
  output logic [31:0]                      sts_stall_cnt
);

  localparam int unsigned CHG_W = $clog2(DATA_WIDTH_IN_BYTES + 1);
  localparam int unsigned BKT_W = TOKEN_WIDTH + 1;
  localparam int unsigned SUM_W = TOKEN_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS} state_t;

  state_t                    state;
  logic signed [BKT_W-1:0]   bucket;
  logic [PERIOD_WIDTH-1:0]   period_cnt;
  logic [PERIOD_WIDTH-1:0]   period_eff;
  logic                      refill;
  logic                      credit_ok;
  logic                      gate;
  logic                      accept;
  logic [CHG_W-1:0]          charge;
  logic signed [SUM_W-1:0]   bucket_ext;
  logic signed [SUM_W-1:0]   inc_ext;
  logic signed [SUM_W-1:0]   chg_ext;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   ceil_ext;
  logic signed [SUM_W-1:0]   floor_ext;
  logic signed [BKT_W-1:0]   bucket_nxt;

  // Strictly positive credit: sign bit clear and not zero.
  assign credit_ok = !bucket[BKT_W-1] && (bucket != '0);

  // Bypass opens the gate everywhere; otherwise only PASS or a credited IDLE.
  assign gate = !cfg_enable || (state == S_PASS) || ((state == S_IDLE) && credit_ok);

  assign in_ready  = !rst && out_ready && gate;
  assign out_valid = !rst && in_valid && gate;
  assign out_data  = in_data;
  assign out_last  = in_last;
  assign out_empty = in_empty;
  assign accept    = in_valid && out_ready && gate;

  assign sts_tokens = bucket;

  // Bytes consumed by the current beat; a last beat drops its empty bytes.
  assign charge = in_last ? (CHG_W'(DATA_WIDTH_IN_BYTES) - CHG_W'(in_empty))
                          : CHG_W'(DATA_WIDTH_IN_BYTES);

  // A zero period behaves as one; >= also absorbs a period shrunk mid-count.
  assign period_eff = (cfg_period == '0) ? PERIOD_WIDTH'(1) : cfg_period;
  assign refill     = (period_cnt >= (period_eff - PERIOD_WIDTH'(1)));

  // Bucket arithmetic in one extra bit so refill and charge never wrap.
  always_comb begin
    bucket_ext = {bucket[BKT_W-1], bucket};
    inc_ext    = refill ? {2'b00, cfg_increment} : '0;
    chg_ext    = (accept && cfg_enable) ? SUM_W'(charge) : '0;
    sum        = bucket_ext + inc_ext - chg_ext;
    ceil_ext   = {2'b00, cfg_burst};
    floor_ext  = {2'b11, {TOKEN_WIDTH{1'b0}}};
    bucket_nxt = BKT_W'(sum);
    if (!cfg_enable) begin
      bucket_nxt = {1'b0, cfg_burst};
    end else if (sum > ceil_ext) begin
      bucket_nxt = {1'b0, cfg_burst};
    end else if (sum < floor_ext) begin
      bucket_nxt = {1'b1, {TOKEN_WIDTH{1'b0}}};
    end
  end

  // Refill period counter and token bucket.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      bucket     <= '0;
    end else begin
      period_cnt <= refill ? '0 : (period_cnt + PERIOD_WIDTH'(1));
      bucket     <= bucket_nxt;
    end
  end

  // Message-boundary FSM plus message and stall statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sts_msg_count <= '0;
      sts_stall_cnt <= '0;
    end else begin
      if (accept && in_last) begin
        sts_msg_count <= sts_msg_count + 32'd1;
      end
      if ((state == S_WAIT) && in_valid) begin
        sts_stall_cnt <= sts_stall_cnt + 32'd1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && gate) begin
            state <= (accept && in_last) ? S_IDLE : S_PASS;
          end else if (in_valid) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cfg_enable && in_valid) begin
            state <= (accept && in_last) ? S_IDLE : S_PASS;
          end else if (credit_ok) begin
            state <= S_IDLE;
          end
        end
        S_PASS: begin
          if (accept && in_last) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rates_token_shaper.sv
// Self-checking bench for rates_token_shaper: beat scoreboard plus bucket,
// rate, stall and reset checks.
module tb_rates_token_shaper;

  localparam int unsigned W  = 4;
  localparam int unsigned TW = 20;
  localparam int unsigned PW = 16;
  localparam int unsigned DW = 8 * W;
  localparam int unsigned EW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_enable = 1'b0;
  logic [PW-1:0]   cfg_period = 16'd4;
  logic [TW-1:0]   cfg_increment = 20'd8;
  logic [TW-1:0]   cfg_burst = 20'd20;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic [EW-1:0]   in_empty = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [EW-1:0]   out_empty;
  logic [TW:0]     sts_tokens;
  logic [31:0]     sts_msg_count;
  logic [31:0]     sts_stall_cnt;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     or_mode = 2;
  int     last_acc_cyc = 0;
  longint sb[$];

  rates_token_shaper #(
    .DATA_WIDTH_IN_BYTES(W), .TOKEN_WIDTH(TW), .PERIOD_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .cfg_increment(cfg_increment), .cfg_burst(cfg_burst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_empty(out_empty),
    .sts_tokens(sts_tokens), .sts_msg_count(sts_msg_count),
    .sts_stall_cnt(sts_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness: 0 = always ready, 1 = random, otherwise held low.
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every beat the sink takes must be the oldest beat offered by the source.
  always @(negedge clk) begin
    longint e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("beat", longint'({out_data, out_last, out_empty}), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic [EW-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_empty = e;
    sb.push_back(longint'({d, l, e}));
  endtask

  task automatic wait_accept(output int n);
    logic acc;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      n++;
      if (acc) last_acc_cyc = cyc;
      if (!acc && n >= 2000) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_msg(input int nbytes, output int cycles);
    int nb;
    int n;
    logic l;
    logic [EW-1:0] e;
    nb     = (nbytes + W - 1) / W;
    cycles = 0;
    for (int i = 0; i < nb; i++) begin
      l = (i == nb - 1);
      e = l ? EW'(nb * W - nbytes) : '0;
      drive_beat(DW'($urandom), l, e);
      wait_accept(n);
      cycles += n;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int n;
    int stall0;
    int msg0;
    int first_cyc;
    int span;

    // Reset asserted mid-message clears gating, bucket and counters.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hdead_beef;
    in_last  = 1'b0;
    @(negedge clk);
    check("bypass_out_valid", out_valid, 1);
    check("held_in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_tokens", longint'($signed(sts_tokens)), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    or_mode = 0;
    @(negedge clk);
    check("rst_msg_count", sts_msg_count, 0);
    check("rst_stall_cnt", sts_stall_cnt, 0);

    // Refill toward a ceiling with no traffic.
    tick();
    rst = 1'b1;
    cfg_enable = 1'b1;
    cfg_period = 16'd4;
    cfg_increment = 20'd8;
    cfg_burst = 20'd20;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("refill_tokens", longint'($signed(sts_tokens)), (k == 0) ? 8 : (k == 1) ? 16 : 20);
    end

    // Deficit: a full bucket, a message that overdraws it, then a stall.
    tick();
    cfg_enable = 1'b0;
    cfg_burst = 20'd100;
    cfg_increment = 20'd0;
    cfg_period = 16'd1000;
    tick();
    tick();
    cfg_enable = 1'b1;
    tick();
    @(negedge clk);
    check("full_bucket", longint'($signed(sts_tokens)), 100);
    tick();
    send_msg(30, n);
    check("msg30_cycles", n, 8);
    @(negedge clk);
    check("after30_tokens", longint'($signed(sts_tokens)), 70);
    tick();
    send_msg(200, n);
    check("msg200_cycles", n, 50);
    @(negedge clk);
    check("after200_tokens", longint'($signed(sts_tokens)), -130);
    tick();
    stall0 = int'(sts_stall_cnt);
    drive_beat(32'h1234_5678, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("deficit_blocked", in_ready, 0);
      @(posedge clk);
    end
    #1;
    cfg_increment = 20'd200;
    cfg_period = 16'd1;
    @(negedge clk);
    check("deficit_stalls", int'(sts_stall_cnt) - stall0, 4);
    tick();
    wait_accept(n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cfg_increment = 20'd0;

    // Rate: one 4-byte credit every 10 cycles admits one message per period.
    cfg_period = 16'd10;
    cfg_increment = 20'd4;
    cfg_burst = 20'd4;
    repeat (3) tick();
    stall0 = int'(sts_stall_cnt);
    first_cyc = 0;
    for (int k = 0; k < 21; k++) begin
      send_msg(4, n);
      if (k == 0) first_cyc = last_acc_cyc;
    end
    span = last_acc_cyc - first_cyc;
    check("rate_span_in_range", longint'(span >= 190 && span <= 210), 1);
    check("stall_per_msg_in_range",
          longint'((int'(sts_stall_cnt) - stall0) >= 140 && (int'(sts_stall_cnt) - stall0) <= 200), 1);

    // Refill and charge in the same cycle.
    cfg_enable = 1'b0;
    cfg_burst = 20'd4;
    cfg_period = 16'd1;
    cfg_increment = 20'd0;
    tick();
    tick();
    cfg_enable = 1'b1;
    cfg_burst = 20'd100;
    tick();
    @(negedge clk);
    check("sim_pre_tokens", longint'($signed(sts_tokens)), 4);
    tick();
    cfg_increment = 20'd4;
    drive_beat(32'hcafe_0001, 1'b1, 2'd0);
    wait_accept(n);
    cfg_increment = 20'd0;
    in_valid = 1'b0;
    check("sim_accept_cycles", n, 1);
    @(negedge clk);
    check("sim_tokens", longint'($signed(sts_tokens)), 4);
    tick();
    cfg_burst = 20'd4;
    cfg_increment = 20'd4;
    tick();
    tick();
    drive_beat(32'hcafe_0002, 1'b1, 2'd0);
    wait_accept(n);
    in_valid = 1'b0;
    @(negedge clk);
    check("sim_clamp_tokens", longint'($signed(sts_tokens)), 4);

    // Bypass with random backpressure, then enable mid-message.
    tick();
    cfg_enable = 1'b0;
    cfg_burst = 20'd50;
    cfg_increment = 20'd0;
    or_mode = 1;
    msg0 = int'(sts_msg_count);
    tick();
    send_msg(5, n);
    send_msg(13, n);
    send_msg(30, n);
    or_mode = 0;
    tick();
    tick();
    @(negedge clk);
    check("bypass_tokens", longint'($signed(sts_tokens)), 50);
    check("bypass_msgs", int'(sts_msg_count) - msg0, 3);
    tick();
    cfg_burst = 20'd0;
    tick();
    tick();
    span = 0;
    for (int i = 0; i < 6; i++) begin
      drive_beat(DW'($urandom), i == 5, 2'd0);
      wait_accept(n);
      span += n;
      if (i == 1) cfg_enable = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("toggle_no_stall", span, 6);
    @(negedge clk);
    check("toggle_tokens", longint'($signed(sts_tokens)), -16);

    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
